// File: rtl/diaosi_types_pkg.sv
// Shared types for the diaosi core: instruction-cache frame layout and fill FSM states.
package diaosi_types_pkg;

    typedef enum logic {
        IDLE_I,
        LD
    } Istate_t;

    typedef struct packed {
        logic [25:0] tag;
        logic        valid;
        logic [31:0] data;
    } Icache_t;

endpackage

// File: rtl/icache_dm16_if.sv
// Fetch-side and bus-controller-side signals of the instruction cache.
interface icache_dm16_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    // Environment view: datapath fetch requests plus bus controller responses.
    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_dm16.sv
// Direct-mapped, read-only instruction cache: 16 one-word frames, combinational hits,
// single-word refill from the bus controller on a miss.
module icache_dm16 #(
    parameter int NSETS = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic          CLK,
    input  logic          nRST,
    icache_dm16_if.slave  ibus
);
    import diaosi_types_pkg::*;

    Icache_t            frames [NSETS];
    Istate_t            state;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   req_tag;
    Icache_t            cur;
    logic               match;
    logic               unused_byte_sel;

    assign idx             = ibus.imemaddr[IDX_W+1:2];
    assign req_tag         = ibus.imemaddr[31:IDX_W+2];
    assign cur             = frames[idx];
    assign match           = cur.valid && (cur.tag == req_tag);
    assign unused_byte_sel = ^ibus.imemaddr[1:0];

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        ibus.ihit     = 1'b0;
        ibus.imemload = '0;
        ibus.iREN     = 1'b0;
        ibus.iaddr    = '0;
        if (state == LD) begin
            ibus.iREN  = 1'b1;
            ibus.iaddr = {ibus.imemaddr[31:2], 2'b00};
        end else if (ibus.imemREN && match) begin
            ibus.ihit     = 1'b1;
            ibus.imemload = cur.data;
        end
    end

    // NOTE: the frames live in flops rather than RAM because reset must clear every
    // valid bit at once; non-blocking assignments keep state and frames updating together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE_I;
            for (int i = 0; i < NSETS; i++) begin
                frames[i] <= '0;
            end
        end else begin
            case (state)
                IDLE_I: begin
                    if (ibus.imemREN && !match) begin
                        state <= LD;
                    end
                end
                LD: begin
                    // A squashed fetch wins over fill data arriving in the same cycle.
                    if (!ibus.imemREN) begin
                        state <= IDLE_I;
                    end else if (!ibus.iwait) begin
                        frames[idx] <= '{tag: req_tag, valid: 1'b1, data: ibus.iload};
                        state       <= IDLE_I;
                    end
                end
                default: state <= IDLE_I;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm16.sv
// Scoreboard bench for icache_dm16: directed scenarios followed by random fetch traffic.
module tb_icache_dm16;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    icache_dm16_if ibus();

    icache_dm16 dut (
        .CLK  (CLK),
        .nRST (nRST),
        .ibus (ibus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        ihit;
        logic [31:0] load;
        logic        iren;
        logic [31:0] iaddr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: what each word-frame holds, and whether a miss is outstanding.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    bit          pending;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
        end
        pending = 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs just after the edge and queue the expected outputs.
    task automatic step(input string name, input bit ren, input logic [31:0] a,
                        input bit w, input logic [31:0] ld, input bit rst);
        exp_t        e;
        int          i;
        logic [25:0] t;
        bit          hit;
        @(posedge CLK);
        #1;
        ibus.imemREN  = ren;
        ibus.imemaddr = a;
        ibus.iwait    = w;
        ibus.iload    = ld;
        i   = int'(a[5:2]);
        t   = a[31:6];
        hit = m_valid[i] && (m_tag[i] == t);
        e.name = name;
        if (rst) begin
            nRST = 1'b0;
            model_reset();
            e.ihit  = 1'b0;
            e.load  = '0;
            e.iren  = 1'b0;
            e.iaddr = '0;
        end else begin
            nRST = 1'b1;
            if (!pending) begin
                e.ihit  = ren && hit;
                e.load  = (ren && hit) ? m_data[i] : 32'h0;
                e.iren  = 1'b0;
                e.iaddr = '0;
                pending = ren && !hit;
            end else begin
                e.ihit  = 1'b0;
                e.load  = '0;
                e.iren  = 1'b1;
                e.iaddr = {a[31:2], 2'b00};
                if (!ren) begin
                    pending = 1'b0;
                end else if (!w) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = t;
                    m_data[i]  = ld;
                    pending    = 1'b0;
                end
            end
        end
        sb.push_back(e);
    endtask

    // Miss, `waits` busy cycles, data return, then one hit cycle.
    task automatic fetch_fill(input string name, input logic [31:0] a, input int waits,
                              input logic [31:0] d);
        step({name, ".miss"}, 1'b1, a, 1'b1, 32'hDEAD_BEEF, 1'b0);
        for (int k = 0; k < waits; k++) begin
            step({name, ".wait"}, 1'b1, a, 1'b1, 32'hDEAD_BEEF, 1'b0);
        end
        step({name, ".fill"}, 1'b1, a, 1'b0, d, 1'b0);
        step({name, ".hit"}, 1'b1, a, 1'b1, 32'hDEAD_BEEF, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".ihit"},     {31'b0, ibus.ihit}, {31'b0, e.ihit});
                check({e.name, ".imemload"}, ibus.imemload,      e.load);
                check({e.name, ".iREN"},     {31'b0, ibus.iREN}, {31'b0, e.iren});
                check({e.name, ".iaddr"},    ibus.iaddr,         e.iaddr);
            end
        end
    end

    initial begin : driver
        logic [31:0] a;
        logic [25:0] tg;
        ibus.imemREN  = 1'b0;
        ibus.imemaddr = '0;
        ibus.iwait    = 1'b1;
        ibus.iload    = '0;
        model_reset();

        step("reset0", 1'b1, 32'h40, 1'b1, 32'h0, 1'b1);
        step("reset1", 1'b1, 32'h40, 1'b0, 32'h1234_5678, 1'b1);

        fetch_fill("fill40", 32'h0000_0040, 3, 32'h2001_0005);
        for (int k = 0; k < 10; k++) begin
            step("rehit40", 1'b1, 32'h0000_0040, 1'b1, $urandom, 1'b0);
        end

        fetch_fill("conflict80", 32'h0000_0080, 1, 32'hAAAA_5555);
        fetch_fill("evicted40", 32'h0000_0040, 1, 32'h2001_0005);

        step("abandon.miss", 1'b1, 32'h0000_0104, 1'b1, 32'h0, 1'b0);
        step("abandon.ld1",  1'b1, 32'h0000_0104, 1'b1, 32'h0, 1'b0);
        step("abandon.drop", 1'b0, 32'h0000_0104, 1'b0, 32'h5555_0000, 1'b0);
        step("abandon.idle", 1'b0, 32'h0000_0104, 1'b0, 32'h0, 1'b0);
        step("abandon.remiss", 1'b1, 32'h0000_0104, 1'b1, 32'h0, 1'b0);
        step("abandon.drop2",  1'b0, 32'h0000_0104, 1'b1, 32'h0, 1'b0);

        fetch_fill("bytesel107", 32'h0000_0107, 2, 32'h0BAD_F00D);
        step("bytesel.hit104", 1'b1, 32'h0000_0104, 1'b1, 32'h0, 1'b0);
        step("bytesel.hit107", 1'b1, 32'h0000_0107, 1'b1, 32'h0, 1'b0);
        step("bytesel.hit105", 1'b1, 32'h0000_0105, 1'b1, 32'h0, 1'b0);

        step("rstld.miss", 1'b1, 32'h0000_0200, 1'b1, 32'h0, 1'b0);
        step("rstld.ld",   1'b1, 32'h0000_0200, 1'b1, 32'h0, 1'b0);
        step("rstld.rst",  1'b1, 32'h0000_0200, 1'b1, 32'h0, 1'b1);
        step("rstld.hold", 1'b1, 32'h0000_0200, 1'b0, 32'h7777_7777, 1'b1);
        fetch_fill("rstld.refill40", 32'h0000_0040, 1, 32'h3003_0003);
        step("rstld.miss104", 1'b1, 32'h0000_0104, 1'b1, 32'h0, 1'b0);
        step("rstld.drop104", 1'b0, 32'h0000_0104, 1'b1, 32'h0, 1'b0);

        // Random traffic: a small tag pool per index keeps hits, misses and conflicts all common.
        a = 32'h0;
        for (int n = 0; n < 1500; n++) begin
            if (!pending || ($urandom_range(0, 9) == 0)) begin
                tg = 26'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) tg = tg | 26'h2A0_0000;
                a = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            end
            step("rand", $urandom_range(0, 99) < 85, a, $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 199) == 0);
        end

        @(negedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_dm16.md
Name: icache_dm16

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage (imem request) and the bus controller's ICACHE_DIAOSI path.
- Built on Icache_t and Istate_t from diaosi_types_pkg: 16 frames, one 32-bit word per frame, 26-bit tag, two-state fill FSM (IDLE_I, LD).
- Answers fetch hits combinationally.
- On a miss it issues a single-word read to the bus controller and installs the returned word.

Parameters:
- NSETS, 16, number of frames; power of two.
- IDX_W, 4, index width, log2(NSETS).
- TAG_W, 26, tag width, 32-2-IDX_W; must equal the Icache_t tag width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- imemREN  in  1  fetch read request from datapath.
- imemaddr  in  32  fetch byte address; tag=[31:6], index=[5:2], [1:0] ignored.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  instruction word; valid only when ihit=1.
- iREN  out  1  read request to bus controller.
- iaddr  out  32  word-aligned fill address to bus controller.
- iwait  in  1  bus busy; fill data valid in a cycle where iREN=1 and iwait=0.
- iload  in  32  fill data from bus controller.

Behaviour:
- Storage:
  - frames[NSETS] of Icache_t, held in flops.
  - Registered state of Istate_t.
  - Everything else is combinational.
- Reset (nRST=0, takes effect immediately, no clock needed):
  - All frames: valid=0, tag=0, data=0.
  - state=IDLE_I.
  - Outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
- Hit logic (combinational):
  - match = frames[idx].valid && frames[idx].tag==imemaddr[31:6].
  - ihit = (state==IDLE_I) && imemREN && match.
  - imemload = frames[idx].data when ihit, else 32'h0.
- State IDLE_I:
  - iREN=0, iaddr=0.
  - imemREN && !match -> LD at next edge.
  - Otherwise stay.
  - No state change on hit.
- State LD:
  - iREN=1; iaddr={imemaddr[31:2],2'b00}, tracking imemaddr combinationally. The datapath must hold imemaddr stable while stalled.
  - ihit=0 for the whole of LD.
  - If imemREN=0: abandon (fetch squashed), no frame write, -> IDLE_I. This takes priority over iwait.
  - Else if iwait=0: at the edge, write frames[idx] = {imemaddr[31:6], 1, iload}, -> IDLE_I.
  - Else stay in LD.
- Timing:
  - Miss detected in cycle 0, LD from cycle 1; iwait falls in cycle k.
  - Frame written at end of cycle k; ihit=1 in cycle k+1.
  - Minimum miss penalty is 2 cycles (iwait=0 in cycle 1).
- Conflict: same index, different tag -> unconditional overwrite. No replacement choice.
- Instructions are never dirty. No writeback, no invalidate, no snoop participation.
- A frame is written only in LD with iwait=0 and imemREN=1. Nothing else alters a frame after reset.
- imemaddr[1:0] are ignored for lookup and cleared in iaddr.
- Reset asserted mid-LD: iREN drops in the same cycle; the pending fill is discarded.
- Reset release: first edge with nRST=1 behaves as IDLE_I with every frame invalid.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x0000_0040, iwait=1 for 3 cycles then 0 with iload=0x2001_0005 -> ihit=0 throughout; iREN=1 with iaddr=0x40 cycles 1..4; cycle 5 ihit=1, imemload=0x2001_0005; iREN=0.
- Repeat fetch of 0x40 for 10 cycles -> ihit=1 every cycle, iREN never asserts.
- Fetch 0x0000_0080 (index 0, new tag) after 0x0000_0040 (index 0) filled, iload=0xAAAA_5555 -> miss, refill; then fetch 0x40 again -> miss (evicted), iREN=1, iaddr=0x40.
- Enter LD for 0x0000_0104 with iwait=1, drop imemREN in cycle 2 -> next cycle state IDLE_I, iREN=0, frame 1 still invalid; re-fetch 0x104 -> misses again.
- Address 0x0000_0107 -> iaddr=0x0000_0104 during fill; after fill, 0x104 and 0x107 both hit with the same data.
- Pull nRST low mid-LD with iwait=1 -> iREN=0 immediately; after release, previously filled 0x40 misses (valid cleared).
